// File: rtl/alu_pkg.sv
// Shared ALU/EX-MEM definitions: FSM encodings, the overflow cause code,
// and the registered EX/MEM bundle.
package alu_pkg;

  localparam logic       ST_RUN  = 1'b0;
  localparam logic       ST_TRAP = 1'b1;

  // MIPS arithmetic-overflow cause code, consumed by CP0.
  localparam logic [4:0] EXC_OV  = 5'h0C;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        zero;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] wdata;
  } mem_bundle_t;

endpackage

// File: rtl/ex_result_fmt.sv
// Combinational result formatting (SLT mux) and trapping-overflow detection.
module ex_result_fmt (
  input  logic        ex_valid,
  input  logic        trap_en,
  input  logic        slt_sel,
  input  logic        alu_ovf,
  input  logic        alu_neg,
  input  logic [31:0] alu_s,
  output logic [31:0] result,
  output logic        fault
);

  assign result = slt_sel ? {31'b0, alu_neg} : alu_s;
  // SLT never traps, and unsigned ops leave trap_en low.
  assign fault  = ex_valid & trap_en & alu_ovf & ~slt_sel;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with overflow trap: squashes the faulting entry,
// holds exc_req/epc, and inserts bubbles until the exception is acknowledged.
module ex_mem_reg
  import alu_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int VECTOR_CNT = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                ex_valid,
  input  logic [31:0]         alu_s,
  input  logic                alu_zero,
  input  logic                alu_ovf,
  input  logic                alu_neg,
  input  logic                trap_en,
  input  logic                slt_sel,
  input  logic [PC_WIDTH-1:0] ex_pc,
  input  logic [4:0]          ex_rd,
  input  logic                ex_regwrite,
  input  logic                ex_memread,
  input  logic                ex_memwrite,
  input  logic [31:0]         ex_wdata,
  input  logic                exc_ack,
  output logic                mem_valid,
  output logic                mem_regwrite,
  output logic                mem_memread,
  output logic                mem_memwrite,
  output logic [31:0]         mem_result,
  output logic                mem_zero,
  output logic [4:0]          mem_rd,
  output logic [31:0]         mem_wdata,
  output logic                exc_req,
  output logic [PC_WIDTH-1:0] epc
);

  // Only the overflow cause exists today; other vector counts are unsupported.
  if (VECTOR_CNT != 0) begin : g_vector_cnt_unsupported
  end

  logic          state;
  logic [31:0]   result_next;
  logic          fault;
  mem_bundle_t   mem_q;

  ex_result_fmt u_fmt (
    .ex_valid (ex_valid),
    .trap_en  (trap_en),
    .slt_sel  (slt_sel),
    .alu_ovf  (alu_ovf),
    .alu_neg  (alu_neg),
    .alu_s    (alu_s),
    .result   (result_next),
    .fault    (fault)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
      mem_q <= '0;
      epc   <= '0;
    end else if (state == ST_TRAP) begin
      // Bubbles regardless of stall; the ack edge itself also captures a bubble.
      mem_q <= '0;
      if (exc_ack) state <= ST_RUN;
    end else if (!stall) begin
      if (flush) begin
        mem_q <= '0;
      end else if (fault) begin
        mem_q.valid    <= 1'b1;
        mem_q.regwrite <= 1'b0;
        mem_q.memread  <= 1'b0;
        mem_q.memwrite <= 1'b0;
        mem_q.zero     <= alu_zero;
        mem_q.rd       <= ex_rd;
        mem_q.result   <= alu_s;
        mem_q.wdata    <= ex_wdata;
        epc            <= ex_pc;
        state          <= ST_TRAP;
      end else begin
        mem_q.valid    <= ex_valid;
        mem_q.regwrite <= ex_regwrite & ex_valid;
        mem_q.memread  <= ex_memread  & ex_valid;
        mem_q.memwrite <= ex_memwrite & ex_valid;
        mem_q.zero     <= alu_zero;
        mem_q.rd       <= ex_rd;
        mem_q.result   <= result_next;
        mem_q.wdata    <= ex_wdata;
      end
    end
  end

  assign exc_req      = (state == ST_TRAP);
  assign mem_valid    = mem_q.valid;
  assign mem_regwrite = mem_q.regwrite;
  assign mem_memread  = mem_q.memread;
  assign mem_memwrite = mem_q.memwrite;
  assign mem_zero     = mem_q.zero;
  assign mem_rd       = mem_q.rd;
  assign mem_result   = mem_q.result;
  assign mem_wdata    = mem_q.wdata;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: capture, SLT, overflow trap/ack, priority, reset.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, ex_valid;
  logic [31:0] alu_s;
  logic        alu_zero, alu_ovf, alu_neg, trap_en, slt_sel;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite;
  logic [31:0] ex_wdata;
  logic        exc_ack;
  logic        mem_valid, mem_regwrite, mem_memread, mem_memwrite;
  logic [31:0] mem_result;
  logic        mem_zero;
  logic [4:0]  mem_rd;
  logic [31:0] mem_wdata;
  logic        exc_req;
  logic [31:0] epc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_mem_reg #(.PC_WIDTH(32), .VECTOR_CNT(0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .alu_s(alu_s), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_neg(alu_neg),
    .trap_en(trap_en), .slt_sel(slt_sel), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_wdata(ex_wdata), .exc_ack(exc_ack), .mem_valid(mem_valid),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_result(mem_result), .mem_zero(mem_zero), .mem_rd(mem_rd), .mem_wdata(mem_wdata),
    .exc_req(exc_req), .epc(epc)
  );

  // Sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; ex_valid = 0; alu_s = '0; alu_zero = 0; alu_ovf = 0;
    alu_neg = 0; trap_en = 0; slt_sel = 0; ex_pc = '0; ex_rd = '0;
    ex_regwrite = 0; ex_memread = 0; ex_memwrite = 0; ex_wdata = '0; exc_ack = 0;
  endtask

  task automatic drive_add(input logic [31:0] s, input logic [4:0] rd, input logic [31:0] pc);
    ex_valid = 1; alu_s = s; alu_ovf = 0; alu_neg = s[31]; alu_zero = (s == 0);
    trap_en = 1; slt_sel = 0; ex_rd = rd; ex_pc = pc; ex_regwrite = 1;
    ex_memread = 0; ex_memwrite = 0; ex_wdata = 32'hA5A5_0000 | {27'b0, rd};
  endtask

  task automatic drive_fault(input logic [31:0] pc);
    drive_add(32'h8000_0000, 5'd10, pc);
    alu_ovf = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    #12;
    if ({mem_valid, mem_regwrite, mem_memread, mem_memwrite, mem_zero, exc_req} !== 6'b0) begin
      fails++; $display("FAIL reset_flags: got %b want 000000",
        {mem_valid, mem_regwrite, mem_memread, mem_memwrite, mem_zero, exc_req});
    end
    tests++;
    if ({mem_result, epc, mem_rd, mem_wdata} !== '0) begin
      fails++; $display("FAIL reset_data: result=%h epc=%h rd=%0d wdata=%h want all 0",
        mem_result, epc, mem_rd, mem_wdata);
    end
    tests++;
    @(negedge clk);
    reset = 1;
    tick();
  endtask

  task automatic test_plain_add();
    idle_inputs();
    drive_add(32'h0000_0005, 5'd8, 32'h0040_0000);
    tick();
    if ({mem_valid, mem_regwrite, exc_req} !== 3'b110 || mem_result !== 32'd5 || mem_rd !== 5'd8) begin
      fails++; $display("FAIL plain_add: v/rw/req=%b result=%h rd=%0d want 110 5 8",
        {mem_valid, mem_regwrite, exc_req}, mem_result, mem_rd);
    end
    tests++;
    // Store with memwrite, and ex_valid=0 must gate control bits.
    ex_memwrite = 1; ex_regwrite = 0; ex_wdata = 32'hDEAD_BEEF;
    tick();
    if ({mem_valid, mem_regwrite, mem_memwrite} !== 3'b101 || mem_wdata !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL store: v/rw/mw=%b wdata=%h want 101 deadbeef",
        {mem_valid, mem_regwrite, mem_memwrite}, mem_wdata);
    end
    tests++;
    ex_valid = 0; ex_regwrite = 1; ex_memread = 1;
    tick();
    if ({mem_valid, mem_regwrite, mem_memread, mem_memwrite} !== 4'b0000) begin
      fails++; $display("FAIL invalid_gate: v/rw/mr/mw=%b want 0000",
        {mem_valid, mem_regwrite, mem_memread, mem_memwrite});
    end
    tests++;
  endtask

  task automatic test_unsigned_ovf();
    idle_inputs();
    drive_fault(32'h0040_0020);
    trap_en = 0;
    tick();
    if ({mem_valid, mem_regwrite, exc_req} !== 3'b110 || mem_result !== 32'h8000_0000) begin
      fails++; $display("FAIL unsigned_ovf: v/rw/req=%b result=%h want 110 80000000",
        {mem_valid, mem_regwrite, exc_req}, mem_result);
    end
    tests++;
  endtask

  task automatic test_slt();
    idle_inputs();
    drive_add(32'hFFFF_FFFE, 5'd3, 32'h0040_0030);
    slt_sel = 1; alu_neg = 1; alu_ovf = 1;
    tick();
    if (mem_result !== 32'h0000_0001 || exc_req !== 1'b0) begin
      fails++; $display("FAIL slt_neg: result=%h req=%b want 00000001 0", mem_result, exc_req);
    end
    tests++;
    alu_neg = 0;
    tick();
    if (mem_result !== 32'h0000_0000) begin
      fails++; $display("FAIL slt_pos: result=%h want 00000000", mem_result);
    end
    tests++;
  endtask

  task automatic test_priority();
    idle_inputs();
    drive_fault(32'h0040_0040);
    flush = 1;
    tick();
    if ({mem_valid, mem_regwrite, exc_req} !== 3'b000) begin
      fails++; $display("FAIL flush_fault: v/rw/req=%b want 000", {mem_valid, mem_regwrite, exc_req});
    end
    tests++;
    flush = 0;
    drive_add(32'h0000_1234, 5'd9, 32'h0040_0044);
    tick();
    stall = 1;
    drive_fault(32'h0040_0048);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_result !== 32'h0000_1234 || mem_rd !== 5'd9 || {mem_valid, mem_regwrite, exc_req} !== 3'b110) begin
        fails++; $display("FAIL stall_hold[%0d]: result=%h rd=%0d v/rw/req=%b want 1234 9 110",
          i, mem_result, mem_rd, {mem_valid, mem_regwrite, exc_req});
      end
      tests++;
    end
    stall = 0;
    idle_inputs();
    tick();
  endtask

  task automatic test_trap();
    int bubbles;
    idle_inputs();
    drive_fault(32'h0040_0010);
    exc_ack = 1;  // ignored in RUN
    tick();
    if ({mem_valid, mem_regwrite, mem_memwrite, mem_memread, exc_req} !== 5'b10001 ||
        mem_result !== 32'h8000_0000 || epc !== 32'h0040_0010) begin
      fails++; $display("FAIL trap_capture: v/rw/mw/mr/req=%b result=%h epc=%h want 10001 80000000 00400010",
        {mem_valid, mem_regwrite, mem_memwrite, mem_memread, exc_req}, mem_result, epc);
    end
    tests++;
    exc_ack = 0;
    bubbles = 0;
    // Keep feeding a valid add (and a stall) with a new PC; both must be ignored.
    drive_add(32'h0000_0077, 5'd4, 32'h0040_0014);
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (!mem_valid) bubbles++;
      if (exc_req !== 1'b1 || epc !== 32'h0040_0010) begin
        fails++; $display("FAIL trap_hold[%0d]: req=%b epc=%h want 1 00400010", i, exc_req, epc);
      end
      tests++;
    end
    stall = 0;
    exc_ack = 1;
    tick();
    if (!mem_valid) bubbles++;
    if (exc_req !== 1'b0 || bubbles !== 3) begin
      fails++; $display("FAIL trap_ack: req=%b bubbles=%0d want 0 3", exc_req, bubbles);
    end
    tests++;
    exc_ack = 0;
    tick();
    if ({mem_valid, mem_regwrite, exc_req} !== 3'b110 || mem_result !== 32'h77 || epc !== 32'h0040_0010) begin
      fails++; $display("FAIL trap_resume: v/rw/req=%b result=%h epc=%h want 110 77 00400010",
        {mem_valid, mem_regwrite, exc_req}, mem_result, epc);
    end
    tests++;
  endtask

  task automatic test_min_width();
    int width;
    idle_inputs();
    drive_fault(32'h0040_0050);
    tick();
    exc_ack = 1;
    idle_inputs();
    exc_ack = 1;
    width = 0;
    for (int i = 0; i < 4; i++) begin
      if (exc_req) width++;
      tick();
    end
    if (width !== 1 || epc !== 32'h0040_0050) begin
      fails++; $display("FAIL min_width: req_cycles=%0d epc=%h want 1 00400050", width, epc);
    end
    tests++;
    exc_ack = 0;
  endtask

  task automatic test_reset_in_trap();
    idle_inputs();
    drive_fault(32'h0040_0060);
    tick();
    idle_inputs();
    #2;
    reset = 0;
    #1;
    if ({exc_req, mem_valid} !== 2'b00 || epc !== 32'h0) begin
      fails++; $display("FAIL reset_trap: req/v=%b epc=%h want 00 0", {exc_req, mem_valid}, epc);
    end
    tests++;
    #2;
    reset = 1;
    drive_add(32'h0000_0042, 5'd7, 32'h0040_0064);
    tick();
    if ({mem_valid, mem_regwrite, exc_req} !== 3'b110 || mem_result !== 32'h42 || mem_rd !== 5'd7) begin
      fails++; $display("FAIL reset_resume: v/rw/req=%b result=%h rd=%0d want 110 42 7",
        {mem_valid, mem_regwrite, exc_req}, mem_result, mem_rd);
    end
    tests++;
  endtask

  initial begin
    test_reset();
    test_plain_add();
    test_unsigned_ovf();
    test_slt();
    test_priority();
    test_trap();
    test_min_width();
    test_reset_in_trap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
